// File: rtl/sig_dump_pkg.sv
// rtl/sig_dump_pkg.sv - shared offsets, status bits, FSM states and helpers for sig_dump_unit
package sig_dump_pkg;

    // Word index of each register, taken from byte address bits [4:2]
    localparam logic [2:0] REG_SIG_START = 3'd0;
    localparam logic [2:0] REG_SIG_END   = 3'd1;
    localparam logic [2:0] REG_HALT      = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_CHECKSUM  = 3'd4;

    // STATUS register bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ABORT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE,
        S_ABORT
    } state_t;

    // Width of a counter that must reach the ack timeout value
    function automatic int to_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Replace only the byte lanes whose enable is set
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sig_dump_regs.sv
// rtl/sig_dump_regs.sv - slave decode, byte-enable merge, ack/err and write lockout (SIG_DUMP_CHECKSUM_EN adds CHECKSUM)
module sig_dump_regs import sig_dump_pkg::*; #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stb_i,
    input  logic [3:0]            we_i,
    input  logic [2:0]            addr_idx_i,
    input  logic [31:0]           wdata_i,
    input  logic                  idle_i,
    input  logic                  align_i,
    input  logic [2:0]            status_i,
`ifdef SIG_DUMP_CHECKSUM_EN
    input  logic [31:0]           checksum_i,
`endif
    output logic [31:0]           rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  halt_start_o,
    output logic [ADDR_WIDTH-1:0] sig_start_o,
    output logic [ADDR_WIDTH-1:0] sig_end_o
);

    logic        wr;
    logic        ok;
    logic [31:0] rd_val;

    // Decode the offset: is this access legal right now, and what would a read return
    always_comb begin
        wr     = |we_i;
        ok     = 1'b0;
        rd_val = '0;
        case (addr_idx_i)
            REG_SIG_START: begin
                ok     = !wr || idle_i;
                rd_val = 32'(sig_start_o);
            end
            REG_SIG_END: begin
                ok     = !wr || idle_i;
                rd_val = 32'(sig_end_o);
            end
            REG_HALT:   ok = !wr || idle_i;
            REG_STATUS: begin
                ok     = !wr;
                rd_val = 32'(status_i);
            end
`ifdef SIG_DUMP_CHECKSUM_EN
            REG_CHECKSUM: begin
                ok     = !wr;
                rd_val = checksum_i;
            end
`endif
            default: ok = 1'b0;
        endcase
    end

    // Only a HALT write that actually enables and sets bit 0 launches a dump
    assign halt_start_o = stb_i && wr && idle_i && (addr_idx_i == REG_HALT)
                          && we_i[0] && wdata_i[0];

    // Registered response one cycle after the strobe, plus address register updates
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            sig_start_o <= '0;
            sig_end_o   <= '0;
        end else begin
            ack_o   <= stb_i && ok;
            err_o   <= stb_i && !ok;
            rdata_o <= (stb_i && ok && !wr) ? rd_val : '0;
            if (align_i) begin
                sig_start_o[1:0] <= 2'b00;
                sig_end_o[1:0]   <= 2'b00;
            end else if (stb_i && ok && wr) begin
                if (addr_idx_i == REG_SIG_START)
                    sig_start_o <= ADDR_WIDTH'(be_merge(32'(sig_start_o), wdata_i, we_i));
                if (addr_idx_i == REG_SIG_END)
                    sig_end_o <= ADDR_WIDTH'(be_merge(32'(sig_end_o), wdata_i, we_i));
            end
        end
    end

endmodule

// File: rtl/sig_dump_unit.sv
// rtl/sig_dump_unit.sv - halt-triggered signature region dumper over a RAM master port (SIG_DUMP_CHECKSUM_EN adds CHECKSUM)
module sig_dump_unit import sig_dump_pkg::*; #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dev_stb_i,
    input  logic [3:0]            dev_we_i,
    input  logic [ADDR_WIDTH-1:0] dev_addr_i,
    input  logic [DATA_WIDTH-1:0] dev_wdata_i,
    output logic [DATA_WIDTH-1:0] dev_rdata_o,
    output logic                  dev_ack_o,
    output logic                  dev_err_o,
    output logic                  mem_stb_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    input  logic                  mem_err_i,
    output logic                  sig_valid_o,
    input  logic                  sig_ready_i,
    output logic [DATA_WIDTH-1:0] sig_data_o,
    output logic                  sig_last_o,
    output logic                  halt_o,
    output logic                  done_o,
    output logic                  abort_o
);

    localparam int TO_W = to_cnt_width(ACK_TIMEOUT);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic [ADDR_WIDTH-1:0] sig_start;
    logic [ADDR_WIDTH-1:0] sig_end;
    logic [ADDR_WIDTH-1:0] start_al;
    logic [ADDR_WIDTH-1:0] end_al;
    logic [TO_W-1:0]       to_cnt;
    logic [2:0]            status;
    logic                  halt_start;
    logic                  unused_addr_bits;
`ifdef SIG_DUMP_CHECKSUM_EN
    logic [31:0]           checksum;
`endif

    assign unused_addr_bits = ^{dev_addr_i[ADDR_WIDTH-1:5], dev_addr_i[1:0]};
    assign start_al = {sig_start[ADDR_WIDTH-1:2], 2'b00};
    assign end_al   = {sig_end[ADDR_WIDTH-1:2], 2'b00};
    assign ptr_next = ptr + ADDR_WIDTH'(4);

    // STATUS view of the FSM; busy covers everything between launch and a terminal state
    always_comb begin
        status              = '0;
        status[STAT_BUSY]   = (state != S_IDLE) && (state != S_DONE) && (state != S_ABORT);
        status[STAT_DONE]   = done_o;
        status[STAT_ABORT]  = abort_o;
    end

    sig_dump_regs #(.ADDR_WIDTH(ADDR_WIDTH)) u_regs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stb_i        (dev_stb_i),
        .we_i         (dev_we_i),
        .addr_idx_i   (dev_addr_i[4:2]),
        .wdata_i      (dev_wdata_i),
        .idle_i       (state == S_IDLE),
        .align_i      (state == S_CHECK),
        .status_i     (status),
`ifdef SIG_DUMP_CHECKSUM_EN
        .checksum_i   (checksum),
`endif
        .rdata_o      (dev_rdata_o),
        .ack_o        (dev_ack_o),
        .err_o        (dev_err_o),
        .halt_start_o (halt_start),
        .sig_start_o  (sig_start),
        .sig_end_o    (sig_end)
    );

    // Dump sequencer: fetch one word, wait for RAM, hold it on the stream until taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ptr         <= '0;
            to_cnt      <= '0;
            mem_stb_o   <= 1'b0;
            mem_addr_o  <= '0;
            sig_valid_o <= 1'b0;
            sig_data_o  <= '0;
            sig_last_o  <= 1'b0;
            halt_o      <= 1'b0;
            done_o      <= 1'b0;
            abort_o     <= 1'b0;
`ifdef SIG_DUMP_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (halt_start) begin
                        halt_o <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
`ifdef SIG_DUMP_CHECKSUM_EN
                    checksum <= '0;
`endif
                    if (start_al >= end_al) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        ptr        <= start_al;
                        mem_addr_o <= start_al;
                        mem_stb_o  <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_stb_o <= 1'b0;
                    to_cnt    <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        sig_valid_o <= 1'b1;
                        sig_data_o  <= mem_rdata_i;
                        sig_last_o  <= (ptr_next >= end_al);
                        state       <= S_EMIT;
                    end else if (mem_err_i || (to_cnt == TO_W'(ACK_TIMEOUT - 1))) begin
                        abort_o <= 1'b1;
                        state   <= S_ABORT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (sig_ready_i) begin
                        sig_valid_o <= 1'b0;
                        sig_last_o  <= 1'b0;
                        ptr         <= ptr_next;
`ifdef SIG_DUMP_CHECKSUM_EN
                        checksum    <= checksum + sig_data_o;
`endif
                        if (sig_last_o) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            mem_addr_o <= ptr_next;
                            mem_stb_o  <= 1'b1;
                            state      <= S_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_dump_unit.sv
// tb/tb_sig_dump_unit.sv - self-checking bench for sig_dump_unit (honours SIG_DUMP_CHECKSUM_EN)
module tb_sig_dump_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dev_stb_i;
    logic [3:0]  dev_we_i;
    logic [31:0] dev_addr_i;
    logic [31:0] dev_wdata_i;
    logic [31:0] dev_rdata_o;
    logic        dev_ack_o;
    logic        dev_err_o;
    logic        mem_stb_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        mem_err_i;
    logic        sig_valid_o;
    logic        sig_ready_i;
    logic [31:0] sig_data_o;
    logic        sig_last_o;
    logic        halt_o;
    logic        done_o;
    logic        abort_o;

    sig_dump_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ACK_TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dev_stb_i(dev_stb_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
        .dev_wdata_i(dev_wdata_i), .dev_rdata_o(dev_rdata_o), .dev_ack_o(dev_ack_o),
        .dev_err_o(dev_err_o), .mem_stb_o(mem_stb_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
        .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i), .sig_data_o(sig_data_o),
        .sig_last_o(sig_last_o), .halt_o(halt_o), .done_o(done_o), .abort_o(abort_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Environment state shared by the RAM responder and the stream consumer
    logic [31:0] ram_ov [logic [31:0]];
    int          ram_mode   = 0;   // 0 answer, 1 never answer, 2 answer with error
    int          ram_lat    = 0;
    int          stb_cnt    = 0;
    logic [31:0] ram_a;
    int          ready_mode = 0;   // 0 always, 1 random, 2 stall first word, 3 never
    int          stall_left = 0;
    int          stalled    = 0;
    int          stable_err = 0;
    int          stb_viol   = 0;
    logic        have_prev  = 1'b0;
    logic [31:0] prev_d;
    logic [31:0] got_d [$];
    logic        got_l [$];

    typedef struct {
        string       name;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        if (ram_ov.exists(a)) return ram_ov[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // RAM slave: one read per strobe, answered after a programmable latency
    initial begin
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0; mem_err_i = 1'b0;
            if (mem_stb_o) begin
                stb_cnt++;
                ram_a = mem_addr_o;
                if (ram_mode != 1) begin
                    @(posedge clk_i); #1;
                    repeat (ram_lat) begin @(posedge clk_i); #1; end
                    if (ram_mode == 0) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = ram_val(ram_a);
                    end else begin
                        mem_err_i = 1'b1;
                    end
                end
            end
        end
    end

    // Stream consumer: choose ready for the coming edge, then log what that edge transfers
    initial begin
        sig_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            case (ready_mode)
                0: sig_ready_i = 1'b1;
                1: sig_ready_i = 1'($urandom_range(0, 1));
                2: if (sig_valid_o && got_d.size() == 0 && stall_left > 0) begin
                       sig_ready_i = 1'b0; stall_left--; stalled++;
                   end else sig_ready_i = 1'b1;
                default: sig_ready_i = 1'b0;
            endcase
            if (sig_valid_o) begin
                if (have_prev && sig_data_o !== prev_d) stable_err++;
                if (sig_ready_i) begin
                    got_d.push_back(sig_data_o);
                    got_l.push_back(sig_last_o);
                    have_prev = 1'b0;
                end else begin
                    prev_d    = sig_data_o;
                    have_prev = 1'b1;
                    if (stb_cnt != got_d.size() + 1) stb_viol++;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    // One slave access, launched and completed on falling edges
    task automatic bus(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic ack, output logic err, output logic [31:0] rd);
        dev_stb_i = 1'b1; dev_we_i = we; dev_addr_i = addr; dev_wdata_i = wd;
        @(negedge clk_i);
        dev_stb_i = 1'b0; dev_we_i = '0;
        ack = dev_ack_o; err = dev_err_o; rd = dev_rdata_o;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic a, e; logic [31:0] r;
        bus(4'h0, addr, 32'h0, a, e, r);
        chk(name, {a, e, r}, {2'b10, exp});
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        stb_cnt = 0;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input string tag);
        logic a, er; logic [31:0] r;
        got_d.delete(); got_l.delete();
        stb_cnt = 0; stable_err = 0; stb_viol = 0;
        bus(4'hF, 32'h0, s, a, er, r);
        bus(4'hF, 32'h4, e, a, er, r);
        bus(4'hF, 32'h8, 32'h1, a, er, r);
        chk({tag, "_halt_wr"}, {a, er}, 2'b10);
    endtask

    // Full dump compared against the region walk computed straight from start/end
    task automatic run_dump(input logic [31:0] s, input logic [31:0] e, input int rmode,
                            input int lat, input string tag);
        int cyc; logic [31:0] exp_q [$]; logic [31:0] sum; logic [31:0] p; logic [31:0] pe;
        ram_mode = 0; ram_lat = lat; ready_mode = rmode;
        launch(s, e, tag);
        cyc = 0;
        while (!(done_o || abort_o) && cyc < 3000) begin @(negedge clk_i); cyc++; end
        chk({tag, "_done"}, {done_o, abort_o, halt_o}, 3'b101);
        p = s & ~32'h3; pe = e & ~32'h3; sum = '0;
        while (p < pe) begin exp_q.push_back(ram_val(p)); sum += ram_val(p); p += 4; end
        chk({tag, "_count"}, got_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            chk({tag, "_data"}, got_d[i], exp_q[i]);
            chk({tag, "_last"}, got_l[i], (i == exp_q.size() - 1));
        end
        chk({tag, "_stable"}, stable_err, 0);
        chk({tag, "_one_fetch"}, stb_viol, 0);
`ifdef SIG_DUMP_CHECKSUM_EN
        rd_chk({tag, "_checksum"}, 32'h10, sum);
`endif
    endtask

    task automatic add_vec(input string n, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic ea, input logic ee,
                           input logic [31:0] erd);
        vec_t v;
        v.name = n; v.we = we; v.addr = addr; v.wdata = wd;
        v.exp_ack = ea; v.exp_err = ee; v.exp_rd = erd;
        vt.push_back(v);
    endtask

    initial begin
        logic a, er; logic [31:0] r; int cyc;
        logic [31:0] s, e;
        rst_i = 1'b1; dev_stb_i = 1'b0; dev_we_i = '0; dev_addr_i = '0; dev_wdata_i = '0;
        @(negedge clk_i); @(negedge clk_i);
        chk("reset_outputs", {dev_rdata_o, dev_ack_o, dev_err_o, mem_stb_o, mem_addr_o,
                              sig_valid_o, sig_data_o, sig_last_o, halt_o, done_o, abort_o}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Register map vectors, all issued while idle
        add_vec("wr_start",     4'hF, 32'h00,       32'h12345678, 1, 0, 32'h0);
        add_vec("rd_start",     4'h0, 32'h00,       32'h0,        1, 0, 32'h12345678);
        add_vec("wr_end_lo",    4'h3, 32'h04,       32'hAAAABBBB, 1, 0, 32'h0);
        add_vec("rd_end_lo",    4'h0, 32'h04,       32'h0,        1, 0, 32'h0000BBBB);
        add_vec("wr_end_hi",    4'hC, 32'h04,       32'hCCCC1111, 1, 0, 32'h0);
        add_vec("rd_end_hi",    4'h0, 32'h04,       32'h0,        1, 0, 32'hCCCCBBBB);
        add_vec("wr_start_b1",  4'h2, 32'h00,       32'h0000EE00, 1, 0, 32'h0);
        add_vec("rd_start_alias", 4'h0, 32'hFFFFFF20, 32'h0,      1, 0, 32'h1234EE78);
        add_vec("rd_halt",      4'h0, 32'h08,       32'h0,        1, 0, 32'h0);
        add_vec("wr_halt_bit0_clear", 4'hF, 32'h08, 32'h0,        1, 0, 32'h0);
        add_vec("wr_halt_lane_off",   4'h2, 32'h08, 32'h1,        1, 0, 32'h0);
        add_vec("rd_status",    4'h0, 32'h0C,       32'h0,        1, 0, 32'h0);
        add_vec("wr_status",    4'hF, 32'h0C,       32'h7,        0, 1, 32'h0);
        add_vec("rd_0x14",      4'h0, 32'h14,       32'h0,        0, 1, 32'h0);
        add_vec("rd_0x1c",      4'h0, 32'h1C,       32'h0,        0, 1, 32'h0);
`ifdef SIG_DUMP_CHECKSUM_EN
        add_vec("rd_checksum",  4'h0, 32'h10,       32'h0,        1, 0, 32'h0);
        add_vec("wr_checksum",  4'hF, 32'h10,       32'h1,        0, 1, 32'h0);
`else
        add_vec("rd_0x10",      4'h0, 32'h10,       32'h0,        0, 1, 32'h0);
`endif
        for (int i = 0; i < vt.size(); i++) begin
            bus(vt[i].we, vt[i].addr, vt[i].wdata, a, er, r);
            chk(vt[i].name, {a, er, r}, {vt[i].exp_ack, vt[i].exp_err, vt[i].exp_rd});
        end
        chk("no_launch_idle", {halt_o, mem_stb_o, done_o}, 3'b000);

        // Three-word dump with the consumer always ready
        ram_ov[32'h100] = 32'hA; ram_ov[32'h104] = 32'hB; ram_ov[32'h108] = 32'hC;
        do_reset();
        run_dump(32'h100, 32'h10C, 0, 0, "basic");
        rd_chk("basic_status", 32'h0C, 32'h2);

        // Empty region finishes without touching RAM
        do_reset();
        ram_mode = 0; ready_mode = 0;
        launch(32'h200, 32'h200, "empty");
        cyc = 0;
        while (!done_o && cyc < 10) begin @(negedge clk_i); cyc++; end
        chk("empty_done_latency_ok", (cyc <= 2), 1);
        repeat (3) @(negedge clk_i);
        chk("empty_no_words", {got_d.size(), stb_cnt}, 0);

        // Consumer holds off the first word for five cycles
        do_reset();
        stall_left = 5; stalled = 0;
        run_dump(32'h600, 32'h608, 2, 1, "stall");
        chk("stall_cycles", stalled, 5);

        // Misaligned bounds get their low bits dropped
        do_reset();
        run_dump(32'h301, 32'h30E, 0, 1, "align");
        rd_chk("align_start", 32'h00, 32'h300);
        rd_chk("align_end",   32'h04, 32'h30C);

        // Checksum wraps modulo 2^32
        ram_ov[32'h400] = 32'hFFFFFFFF; ram_ov[32'h404] = 32'h2;
        do_reset();
        run_dump(32'h400, 32'h408, 0, 0, "csum");
`ifdef SIG_DUMP_CHECKSUM_EN
        rd_chk("csum_value", 32'h10, 32'h1);
`else
        bus(4'h0, 32'h10, 32'h0, a, er, r);
        chk("no_csum_err", {a, er}, 2'b01);
`endif

        // RAM never answers: abort after the timeout and stop fetching
        do_reset();
        ram_mode = 1; ready_mode = 0;
        launch(32'h500, 32'h508, "tmo");
        cyc = 0;
        while (!abort_o && cyc < 40) begin @(negedge clk_i); cyc++; end
        chk("tmo_latency", cyc, 18);
        rd_chk("tmo_status", 32'h0C, 32'h4);
        repeat (10) @(negedge clk_i);
        chk("tmo_single_fetch", {stb_cnt, done_o, abort_o}, {32'd1, 2'b01});

        // Writes while busy are rejected and leave the register alone
        do_reset();
        ram_mode = 1;
        launch(32'h500, 32'h508, "busy");
        bus(4'hF, 32'h04, 32'hDEAD0000, a, er, r);
        chk("busy_wr_end_err", {a, er}, 2'b01);
        rd_chk("busy_end_kept", 32'h04, 32'h508);
        rd_chk("busy_status", 32'h0C, 32'h1);

        // RAM error aborts
        do_reset();
        ram_mode = 2;
        launch(32'h700, 32'h710, "merr");
        cyc = 0;
        while (!abort_o && cyc < 40) begin @(negedge clk_i); cyc++; end
        repeat (5) @(negedge clk_i);
        chk("merr_abort", {abort_o, done_o, stb_cnt}, {2'b10, 32'd1});

        // Reset while a word sits on the stream clears everything
        do_reset();
        ram_mode = 0; ram_lat = 0; ready_mode = 3;
        launch(32'h800, 32'h808, "rst");
        cyc = 0;
        while (!sig_valid_o && cyc < 40) begin @(negedge clk_i); cyc++; end
        chk("rst_reached_emit", sig_valid_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_emit_outputs", {dev_rdata_o, dev_ack_o, dev_err_o, mem_stb_o, mem_addr_o,
                                     sig_valid_o, sig_data_o, sig_last_o, halt_o, done_o, abort_o}, 0);
        rst_i = 1'b0;
        ready_mode = 0;
        @(negedge clk_i);
        rd_chk("rst_start_zero", 32'h00, 32'h0);
        rd_chk("rst_status_zero", 32'h0C, 32'h0);

        // Random regions, latencies and back-pressure
        for (int it = 0; it < 25; it++) begin
            s = 32'h1000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                e = s - 32'($urandom_range(0, 12));
            else
                e = (s & ~32'h3) + 32'($urandom_range(0, 6)) * 4 + 32'($urandom_range(0, 3));
            do_reset();
            run_dump(s, e, 1, $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
